// File: rtl/ysyx_22040632_axi_sram.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22040632_axi_sram
// Brief   : AXI4 slave (INCR, 64-bit beats) over a single-port MEM_DEPTH x 64 array.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040632_axi_sram #(
    parameter int          ID_WIDTH  = 4,
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int          MEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                axi_aw_valid_i,
    output logic                axi_aw_ready_o,
    input  logic [31:0]         axi_aw_addr_i,
    input  logic [ID_WIDTH-1:0] axi_aw_id_i,
    input  logic [7:0]          axi_aw_len_i,
    input  logic                axi_w_valid_i,
    output logic                axi_w_ready_o,
    input  logic [63:0]         axi_w_data_i,
    input  logic [7:0]          axi_w_strb_i,
    input  logic                axi_w_last_i,
    output logic                axi_b_valid_o,
    input  logic                axi_b_ready_i,
    output logic [1:0]          axi_b_resp_o,
    output logic [ID_WIDTH-1:0] axi_b_id_o,
    input  logic                axi_ar_valid_i,
    output logic                axi_ar_ready_o,
    input  logic [31:0]         axi_ar_addr_i,
    input  logic [ID_WIDTH-1:0] axi_ar_id_i,
    input  logic [7:0]          axi_ar_len_i,
    output logic                axi_r_valid_o,
    input  logic                axi_r_ready_i,
    output logic [63:0]         axi_r_data_o,
    output logic [1:0]          axi_r_resp_o,
    output logic                axi_r_last_o,
    output logic [ID_WIDTH-1:0] axi_r_id_o
);

    localparam int         C_AW          = $clog2(MEM_DEPTH);
    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_RD       = 2'd1;
    localparam logic [1:0] C_ST_WR       = 2'd2;
    localparam logic [1:0] C_ST_WB       = 2'd3;
    localparam logic [1:0] C_RESP_OKAY   = 2'b00;
    localparam logic [1:0] C_RESP_SLVERR = 2'b10;
    localparam logic [1:0] C_RESP_DECERR = 2'b11;

    logic [63:0]         mem_q [MEM_DEPTH];

    logic [1:0]          state_q,   state_d;
    logic [31:0]         addr_q,    addr_d;
    logic [ID_WIDTH-1:0] id_q,      id_d;
    logic [7:0]          len_q,     len_d;
    logic [7:0]          beat_q,    beat_d;
    logic                over_q,    over_d;
    logic                prio_wr_q, prio_wr_d;
    logic                r_valid_q, r_valid_d;
    logic [63:0]         r_data_q,  r_data_d;
    logic [1:0]          r_resp_q,  r_resp_d;
    logic                r_last_q,  r_last_d;
    logic                b_valid_q, b_valid_d;
    logic [1:0]          b_resp_q,  b_resp_d;

    logic                w_ar_ready;
    logic                w_aw_ready;
    logic                w_w_ready;
    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_r_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic [31:0]         w_rd_addr;
    logic [31:0]         w_rd_word;
    logic                w_rd_ok;
    logic [63:0]         w_rd_data;
    logic [31:0]         w_wr_word;
    logic                w_wr_ok;
    logic                w_mem_we;
    logic [1:0]          w_beat_resp;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_ar_hs = w_ar_ready && axi_ar_valid_i;
    assign w_aw_hs = w_aw_ready && axi_aw_valid_i;
    assign w_r_hs  = r_valid_q && axi_r_ready_i;
    assign w_w_hs  = w_w_ready && axi_w_valid_i;
    assign w_b_hs  = b_valid_q && axi_b_ready_i;

    // Read port looks one beat ahead so r_data is registered when r_valid rises.
    assign w_rd_addr = (state_q == C_ST_IDLE) ? axi_ar_addr_i : (addr_q + 32'd8);
    assign w_rd_word = (w_rd_addr - MEM_BASE) >> 3;
    assign w_rd_ok   = (w_rd_addr >= MEM_BASE) && (w_rd_word < 32'(MEM_DEPTH));
    assign w_rd_data = w_rd_ok ? mem_q[w_rd_word[C_AW-1:0]] : 64'd0;

    assign w_wr_word = (addr_q - MEM_BASE) >> 3;
    assign w_wr_ok   = (addr_q >= MEM_BASE) && (w_wr_word < 32'(MEM_DEPTH));
    assign w_mem_we  = w_w_hs && !over_q && w_wr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_ar_hs) begin
                    state_d = C_ST_RD;
                end else if (w_aw_hs) begin
                    state_d = C_ST_WR;
                end
            end
            C_ST_RD: if (w_r_hs && r_last_q)     state_d = C_ST_IDLE;
            C_ST_WR: if (w_w_hs && axi_w_last_i) state_d = C_ST_WB;
            C_ST_WB: if (w_b_hs)                 state_d = C_ST_IDLE;
            default: state_d = C_ST_IDLE;
        endcase
    end

    // Readies are gated by rst so every output is low for the whole reset.
    always_comb begin
        w_ar_ready = 1'b0;
        w_aw_ready = 1'b0;
        w_w_ready  = 1'b0;
        if (!rst) begin
            case (state_q)
                C_ST_IDLE: begin
                    w_ar_ready = axi_ar_valid_i && (!axi_aw_valid_i || !prio_wr_q);
                    w_aw_ready = axi_aw_valid_i && (!axi_ar_valid_i ||  prio_wr_q);
                end
                C_ST_WR: w_w_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        addr_d      = addr_q;
        id_d        = id_q;
        len_d       = len_q;
        beat_d      = beat_q;
        over_d      = over_q;
        prio_wr_d   = prio_wr_q;
        r_valid_d   = r_valid_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        r_last_d    = r_last_q;
        b_valid_d   = b_valid_q;
        b_resp_d    = b_resp_q;
        w_beat_resp = C_RESP_OKAY;
        case (state_q)
            C_ST_IDLE: begin
                if (w_ar_hs) begin
                    addr_d    = axi_ar_addr_i;
                    id_d      = axi_ar_id_i;
                    len_d     = axi_ar_len_i;
                    beat_d    = 8'd0;
                    r_valid_d = 1'b1;
                    r_data_d  = w_rd_data;
                    r_resp_d  = w_rd_ok ? C_RESP_OKAY : C_RESP_DECERR;
                    r_last_d  = (axi_ar_len_i == 8'd0);
                    if (axi_aw_valid_i) prio_wr_d = 1'b1;
                end else if (w_aw_hs) begin
                    addr_d   = axi_aw_addr_i;
                    id_d     = axi_aw_id_i;
                    len_d    = axi_aw_len_i;
                    beat_d   = 8'd0;
                    over_d   = 1'b0;
                    b_resp_d = C_RESP_OKAY;
                    if (axi_ar_valid_i) prio_wr_d = 1'b0;
                end
            end
            C_ST_RD: begin
                if (w_r_hs) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        r_data_d  = 64'd0;
                        r_resp_d  = C_RESP_OKAY;
                    end else begin
                        addr_d   = addr_q + 32'd8;
                        beat_d   = beat_q + 8'd1;
                        r_data_d = w_rd_data;
                        r_resp_d = w_rd_ok ? C_RESP_OKAY : C_RESP_DECERR;
                        r_last_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            C_ST_WR: begin
                if (w_w_hs) begin
                    addr_d = addr_q + 32'd8;
                    // Once past the announced length, beats are only drained.
                    if (!over_q) begin
                        if (!w_wr_ok) w_beat_resp = C_RESP_DECERR;
                        if (axi_w_last_i != (beat_q == len_q)) begin
                            w_beat_resp = worst(w_beat_resp, C_RESP_SLVERR);
                        end
                        if (beat_q == len_q) begin
                            over_d = !axi_w_last_i;
                        end else begin
                            beat_d = beat_q + 8'd1;
                        end
                    end
                    b_resp_d = worst(b_resp_q, w_beat_resp);
                    if (axi_w_last_i) b_valid_d = 1'b1;
                end
            end
            C_ST_WB: begin
                if (w_b_hs) begin
                    b_valid_d = 1'b0;
                    b_resp_d  = C_RESP_OKAY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= 32'd0;
            id_q      <= '0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            over_q    <= 1'b0;
            prio_wr_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= 64'd0;
            r_resp_q  <= 2'b00;
            r_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
        end else begin
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            over_q    <= over_d;
            prio_wr_q <= prio_wr_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
        end
    end

    // Array is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (axi_w_strb_i[b]) begin
                    mem_q[w_wr_word[C_AW-1:0]][8*b +: 8] <= axi_w_data_i[8*b +: 8];
                end
            end
        end
    end

    assign axi_aw_ready_o = w_aw_ready;
    assign axi_ar_ready_o = w_ar_ready;
    assign axi_w_ready_o  = w_w_ready;
    assign axi_b_valid_o  = b_valid_q;
    assign axi_b_resp_o   = b_valid_q ? b_resp_q : 2'b00;
    assign axi_b_id_o     = (b_valid_q || r_valid_q) ? id_q : '0;
    assign axi_r_valid_o  = r_valid_q;
    assign axi_r_data_o   = r_data_q;
    assign axi_r_resp_o   = r_resp_q;
    assign axi_r_last_o   = r_last_q;
    assign axi_r_id_o     = r_valid_q ? id_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040632_axi_sram.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22040632_axi_sram
// Brief   : Directed self-checking bench for the AXI SRAM slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_22040632_axi_sram;

    logic        clk;
    logic        rst;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;

    int n_cmp;
    int n_fail;

    logic [63:0] tv_data [16];
    logic [7:0]  tv_strb [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    logic [63:0] fs_data [16];
    logic        fs_last [16];
    logic        rd_lat_ok;
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid;

    ysyx_22040632_axi_sram #(
        .ID_WIDTH (4),
        .MEM_BASE (32'h8000_0000),
        .MEM_DEPTH(4096)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_aw_valid_i(aw_valid),
        .axi_aw_ready_o(aw_ready),
        .axi_aw_addr_i (aw_addr),
        .axi_aw_id_i   (aw_id),
        .axi_aw_len_i  (aw_len),
        .axi_w_valid_i (w_valid),
        .axi_w_ready_o (w_ready),
        .axi_w_data_i  (w_data),
        .axi_w_strb_i  (w_strb),
        .axi_w_last_i  (w_last),
        .axi_b_valid_o (b_valid),
        .axi_b_ready_i (b_ready),
        .axi_b_resp_o  (b_resp),
        .axi_b_id_o    (b_id),
        .axi_ar_valid_i(ar_valid),
        .axi_ar_ready_o(ar_ready),
        .axi_ar_addr_i (ar_addr),
        .axi_ar_id_i   (ar_id),
        .axi_ar_len_i  (ar_len),
        .axi_r_valid_o (r_valid),
        .axi_r_ready_i (r_ready),
        .axi_r_data_o  (r_data),
        .axi_r_resp_o  (r_resp),
        .axi_r_last_o  (r_last),
        .axi_r_id_o    (r_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Handshake helpers: entered and left at 1 time unit after a rising edge.
    task automatic wait_aw_hs();
        int t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (aw_ready) break;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL aw_timeout: aw_ready got 0 want 1 within 50 cycles");
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic wait_ar_hs();
        int t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (ar_ready) break;
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL ar_timeout: ar_ready got 0 want 1 within 50 cycles");
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic send_w(input int nb);
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            w_valid = 1'b1;
            w_data  = tv_data[i];
            w_strb  = tv_strb[i];
            w_last  = (i == nb - 1);
            while (t < 50) begin
                @(negedge clk);
                if (w_ready) break;
                t++;
            end
            if (t >= 50) begin
                n_cmp++; n_fail++;
                $display("FAIL w_timeout: w_ready got 0 want 1 at beat %0d", i);
            end
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic get_b();
        int t = 0;
        b_ready   = 1'b1;
        got_bresp = 2'bxx;
        got_bid   = 4'hx;
        while (t < 50) begin
            @(negedge clk);
            if (b_valid) begin
                got_bresp = b_resp;
                got_bid   = b_id;
                break;
            end
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL b_timeout: b_valid got 0 want 1 within 50 cycles");
        end
        @(posedge clk); #1;
        b_ready = 1'b0;
    endtask

    task automatic get_r(input int nb, input bit stall);
        int  beat = 0;
        int  c    = 0;
        bit  seen = 0;
        rd_lat_ok = 1'b0;
        r_ready   = stall ? 1'b0 : 1'b1;
        while (beat < nb && c < 200) begin
            @(negedge clk);
            if (c == 0) rd_lat_ok = r_valid;
            if (r_valid && !seen) begin
                fs_data[beat] = r_data;
                fs_last[beat] = r_last;
                seen = 1;
            end
            if (r_valid && r_ready) begin
                rd_data[beat] = r_data;
                rd_resp[beat] = r_resp;
                rd_last[beat] = r_last;
                rd_id[beat]   = r_id;
                beat++;
                seen = 0;
            end
            @(posedge clk); #1;
            c++;
            r_ready = stall ? ((c % 2) == 1) : 1'b1;
        end
        r_ready = 1'b0;
        if (beat < nb) begin
            n_cmp++; n_fail++;
            $display("FAIL r_timeout: beats got %0d want %0d", beat, nb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; aw_valid = 1'b1; ar_valid = 1'b1; w_valid = 1'b1;
        aw_addr = 32'h8000_0000; ar_addr = 32'h8000_0000;
        aw_id = 0; ar_id = 0; aw_len = 0; ar_len = 0;
        w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; r_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (aw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aw_ready got %b want 0", aw_ready); end
        n_cmp++; if (ar_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ar_ready got %b want 0", ar_ready); end
        n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL rst_w_ready got %b want 0", w_ready); end
        n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r_valid got %b want 0", r_valid); end
        n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got %b want 0", b_valid); end
        n_cmp++; if (r_data !== 64'd0) begin n_fail++; $display("FAIL rst_r_data got %h want 0", r_data); end
        aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_burst_write();
        for (int i = 0; i < 4; i++) begin
            tv_data[i] = {8{8'(i + 1)}};
            tv_strb[i] = 8'hFF;
        end
        aw_addr = 32'h8000_0000; aw_id = 4'd3; aw_len = 8'd3; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(4);
        get_b();
        n_cmp++; if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL bw_bresp got %b want 00", got_bresp); end
        n_cmp++; if (got_bid !== 4'd3) begin n_fail++; $display("FAIL bw_bid got %h want 3", got_bid); end
    endtask

    task automatic test_single_rw();
        tv_data[0] = 64'h1122_3344_5566_7788; tv_strb[0] = 8'hFF;
        aw_addr = 32'h8000_0008; aw_id = 4'd2; aw_len = 8'd0; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(1);
        get_b();
        n_cmp++; if (got_bresp !== 2'b00) begin n_fail++; $display("FAIL s_bresp got %b want 00", got_bresp); end
        n_cmp++; if (got_bid !== 4'd2) begin n_fail++; $display("FAIL s_bid got %h want 2", got_bid); end
        ar_addr = 32'h8000_0008; ar_id = 4'd5; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_lat_ok !== 1'b1) begin n_fail++; $display("FAIL s_rlat r_valid got %b want 1 one cycle after AR", rd_lat_ok); end
        n_cmp++; if (rd_data[0] !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL s_rdata got %h want 1122334455667788", rd_data[0]); end
        n_cmp++; if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL s_rlast got %b want 1", rd_last[0]); end
        n_cmp++; if (rd_id[0] !== 4'd5) begin n_fail++; $display("FAIL s_rid got %h want 5", rd_id[0]); end
        n_cmp++; if (rd_resp[0] !== 2'b00) begin n_fail++; $display("FAIL s_rresp got %b want 00", rd_resp[0]); end
    endtask

    task automatic test_partial_strobe();
        tv_data[0] = 64'hAAAA_AAAA_AAAA_AAAA; tv_strb[0] = 8'h0F;
        aw_addr = 32'h8000_0008; aw_id = 4'd1; aw_len = 8'd0; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(1);
        get_b();
        ar_addr = 32'h8000_0008; ar_id = 4'd6; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h1122_3344_AAAA_AAAA) begin n_fail++; $display("FAIL strb_rdata got %h want 11223344aaaaaaaa", rd_data[0]); end
    endtask

    task automatic test_read_burst_stall();
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h0101_0101_0101_0101;
        exp_d[1] = 64'h1122_3344_AAAA_AAAA;
        exp_d[2] = 64'h0303_0303_0303_0303;
        exp_d[3] = 64'h0404_0404_0404_0404;
        ar_addr = 32'h8000_0000; ar_id = 4'd9; ar_len = 8'd3; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(4, 1'b1);
        n_cmp++; if (rd_lat_ok !== 1'b1) begin n_fail++; $display("FAIL rb_rlat r_valid got %b want 1", rd_lat_ok); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL rb_data[%0d] got %h want %h", i, rd_data[i], exp_d[i]); end
            n_cmp++; if (fs_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL rb_stall_data[%0d] got %h want %h", i, fs_data[i], exp_d[i]); end
            n_cmp++; if (rd_last[i] !== (i == 3)) begin n_fail++; $display("FAIL rb_last[%0d] got %b want %b", i, rd_last[i], (i == 3)); end
            n_cmp++; if (fs_last[i] !== (i == 3)) begin n_fail++; $display("FAIL rb_stall_last[%0d] got %b want %b", i, fs_last[i], (i == 3)); end
        end
        n_cmp++; if (rd_id[3] !== 4'd9) begin n_fail++; $display("FAIL rb_id got %h want 9", rd_id[3]); end
    endtask

    task automatic test_conflict();
        // First conflict: read wins; pending write is served afterwards.
        ar_addr = 32'h8000_0000; ar_id = 4'd4; ar_len = 8'd0;
        aw_addr = 32'h8000_0028; aw_id = 4'd7; aw_len = 8'd0;
        tv_data[0] = 64'h5555_5555_5555_5555; tv_strb[0] = 8'hFF;
        ar_valid = 1'b1; aw_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (ar_ready !== 1'b1) begin n_fail++; $display("FAIL c1_ar_ready got %b want 1", ar_ready); end
        n_cmp++; if (aw_ready !== 1'b0) begin n_fail++; $display("FAIL c1_aw_ready got %b want 0", aw_ready); end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h0101_0101_0101_0101) begin n_fail++; $display("FAIL c1_rdata got %h want 0101010101010101", rd_data[0]); end
        wait_aw_hs();
        send_w(1);
        get_b();
        n_cmp++; if (got_bid !== 4'd7) begin n_fail++; $display("FAIL c1_bid got %h want 7", got_bid); end
        // Second conflict: write wins.
        ar_addr = 32'h8000_0028; ar_id = 4'd8; ar_len = 8'd0;
        aw_addr = 32'h8000_0030; aw_id = 4'd2; aw_len = 8'd0;
        tv_data[0] = 64'h6666_6666_6666_6666;
        ar_valid = 1'b1; aw_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (aw_ready !== 1'b1) begin n_fail++; $display("FAIL c2_aw_ready got %b want 1", aw_ready); end
        n_cmp++; if (ar_ready !== 1'b0) begin n_fail++; $display("FAIL c2_ar_ready got %b want 0", ar_ready); end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        send_w(1);
        get_b();
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h5555_5555_5555_5555) begin n_fail++; $display("FAIL c2_rdata got %h want 5555555555555555", rd_data[0]); end
        n_cmp++; if (rd_id[0] !== 4'd8) begin n_fail++; $display("FAIL c2_rid got %h want 8", rd_id[0]); end
    endtask

    task automatic test_out_of_range();
        ar_addr = 32'h7FFF_FFF8; ar_id = 4'd3; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_resp[0] !== 2'b11) begin n_fail++; $display("FAIL oor_rresp got %b want 11", rd_resp[0]); end
        n_cmp++; if (rd_data[0] !== 64'd0) begin n_fail++; $display("FAIL oor_rdata got %h want 0", rd_data[0]); end
        tv_data[0] = 64'hDEAD_BEEF_DEAD_BEEF; tv_strb[0] = 8'hFF;
        aw_addr = 32'h8000_8000; aw_id = 4'd1; aw_len = 8'd0; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(1);
        get_b();
        n_cmp++; if (got_bresp !== 2'b11) begin n_fail++; $display("FAIL oor_bresp got %b want 11", got_bresp); end
        ar_addr = 32'h8000_0000; ar_id = 4'd0; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h0101_0101_0101_0101) begin n_fail++; $display("FAIL oor_nowrite got %h want 0101010101010101", rd_data[0]); end
    endtask

    task automatic test_wlast_mismatch();
        // Early w_last: len 3 but only two beats.
        tv_data[0] = 64'h0A0A_0A0A_0A0A_0A0A; tv_strb[0] = 8'hFF;
        tv_data[1] = 64'h0B0B_0B0B_0B0B_0B0B; tv_strb[1] = 8'hFF;
        aw_addr = 32'h8000_0020; aw_id = 4'd5; aw_len = 8'd3; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(2);
        get_b();
        n_cmp++; if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL early_bresp got %b want 10", got_bresp); end
        // Missing w_last: len 0 but two beats; second beat must be dropped.
        tv_data[0] = 64'h7777_7777_7777_7777;
        tv_data[1] = 64'h8888_8888_8888_8888;
        aw_addr = 32'h8000_0038; aw_id = 4'd6; aw_len = 8'd0; aw_valid = 1'b1;
        wait_aw_hs();
        send_w(2);
        get_b();
        n_cmp++; if (got_bresp !== 2'b10) begin n_fail++; $display("FAIL miss_bresp got %b want 10", got_bresp); end
        ar_addr = 32'h8000_0020; ar_id = 4'd2; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h0A0A_0A0A_0A0A_0A0A) begin n_fail++; $display("FAIL early_rdata got %h want 0a0a0a0a0a0a0a0a", rd_data[0]); end
        ar_addr = 32'h8000_0038; ar_len = 8'd1; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(2, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h7777_7777_7777_7777) begin n_fail++; $display("FAIL miss_rdata got %h want 7777777777777777", rd_data[0]); end
        n_cmp++; if (rd_data[1] === 64'h8888_8888_8888_8888) begin n_fail++; $display("FAIL miss_drop got %h want not 8888888888888888", rd_data[1]); end
    endtask

    task automatic test_reset_mid_burst();
        ar_addr = 32'h8000_0000; ar_id = 4'd1; ar_len = 8'd3; ar_valid = 1'b1;
        wait_ar_hs();
        r_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_r_valid got %b want 0", r_valid); end
        n_cmp++; if (r_data !== 64'd0) begin n_fail++; $display("FAIL mrst_r_data got %h want 0", r_data); end
        r_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ar_addr = 32'h8000_0018; ar_id = 4'd9; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ar_hs();
        get_r(1, 1'b0);
        n_cmp++; if (rd_data[0] !== 64'h0404_0404_0404_0404) begin n_fail++; $display("FAIL mrst_rdata got %h want 0404040404040404", rd_data[0]); end
        n_cmp++; if (rd_id[0] !== 4'd9) begin n_fail++; $display("FAIL mrst_rid got %h want 9", rd_id[0]); end
        n_cmp++; if (rd_last[0] !== 1'b1) begin n_fail++; $display("FAIL mrst_rlast got %b want 1", rd_last[0]); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_burst_write();
        test_single_rw();
        test_partial_strobe();
        test_read_burst_stall();
        test_conflict();
        test_out_of_range();
        test_wlast_mismatch();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
